// File: rtl/handshaking_slave.sv
// handshaking_slave: receiving end of a valid/ready byte handshake.
// Accepted words are buffered in a DEPTH-entry circular FIFO and presented to a
// local consumer on a second valid/ready pair. The sender only sees back-pressure
// (data_ready low) when the FIFO is full.
//
// Full/empty are derived from a registered occupancy count, never from pointer
// compares, so the pointers are free to wrap naturally. DEPTH must be a power of
// two and at least 2.
//
// Optional build macro HS_SLAVE_CNT_EN adds rx_count, a 16-bit wrapping count of
// accepted pushes (cleared by reset, unaffected by pops).

module handshaking_slave #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
`ifdef HS_SLAVE_CNT_EN
    output logic [15:0]           rx_count,
`endif
    output logic [PTR_W:0]        fill_level
);

    localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CntOne  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CntZero = '0;
    localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StPartial = 2'd1,
        StFull    = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic push;
    logic pop;

    // Handshake outputs decode registered state only; rst gating keeps data_ready
    // low for the whole time reset is asserted.
    always_comb begin
        data_ready = rst && (state_q != StFull);
        rx_valid   = (state_q != StEmpty);
        // Memory is never cleared, so mask the head word while nothing is stored.
        rx_data    = rx_valid ? mem_q[rd_ptr_q] : '0;
        fill_level = count_q;
        push       = data_valid && data_ready;
        pop        = rx_valid && rx_ready;
    end

    // Next-state logic: count-based FSM plus pointer advance.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        unique case (state_q)
            StEmpty: begin
                // rx_valid is low here, so a pop cannot happen.
                if (push) begin
                    count_d = count_q + CntOne;
                    state_d = (count_d == CntFull) ? StFull : StPartial;
                end
            end
            StPartial: begin
                if (push && !pop) begin
                    count_d = count_q + CntOne;
                    if (count_d == CntFull) begin
                        state_d = StFull;
                    end
                end else if (pop && !push) begin
                    count_d = count_q - CntOne;
                    if (count_d == CntZero) begin
                        state_d = StEmpty;
                    end
                end
            end
            StFull: begin
                // data_ready is low here, so only a pop can happen.
                if (pop) begin
                    count_d = count_q - CntOne;
                    state_d = StPartial;
                end
            end
            default: begin
                state_d  = StEmpty;
                count_d  = CntZero;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end
        endcase
    end

    // State, occupancy and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StEmpty;
            count_q  <= CntZero;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef HS_SLAVE_CNT_EN
    logic [15:0] rx_cnt_q, rx_cnt_d;

    // Accepted-push counter, wraps at 16 bits.
    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (push) begin
            rx_cnt_d = rx_cnt_q + 16'd1;
        end
        rx_count = rx_cnt_q;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt_q <= '0;
        end else begin
            rx_cnt_q <= rx_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_handshaking_slave.sv
// Self-checking bench for handshaking_slave (DATA_WIDTH=8, DEPTH=4).
// A negedge monitor pushes every accepted word into a queue and checks each
// popped word against the queue head, so ordering is verified in every test.

module tb_handshaking_slave;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [PW:0]   fill_level;
`ifdef HS_SLAVE_CNT_EN
    logic [15:0]   rx_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;
    logic [DW-1:0] sb_q[$];

    handshaking_slave #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
`ifdef HS_SLAVE_CNT_EN
        .rx_count  (rx_count),
`endif
        .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: decide what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst && data_valid && data_ready) begin
            sb_q.push_back(data_in);
        end
        if (rst && rx_valid && rx_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_pop: got rx_data=%h, expected no word (queue empty)",
                         rx_data);
            end else begin
                logic [DW-1:0] exp_w;
                exp_w = sb_q.pop_front();
                pop_cnt++;
                if (rx_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL scoreboard_data: got rx_data=%h, expected %h", rx_data, exp_w);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        data_valid = 1'b0;
        rx_ready   = 1'b0;
        data_in    = '0;
        repeat (2) step();
        sb_q.delete();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        data_valid = 1'b0;
        rx_ready   = 1'b0;
        data_in    = '0;
        repeat (3) step();
        n_checks++;
        if (data_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b, expected 0", data_ready);
        end
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid);
        end
        n_checks++;
        if (fill_level !== 3'd0) begin
            n_fail++; $display("FAIL reset_fill: got %0d, expected 0", fill_level);
        end
        n_checks++;
        if (rx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_rx_data: got %h, expected 00", rx_data);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (data_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_ready: got %b, expected 1", data_ready);
        end
    endtask

    task automatic test_single();
        data_in    = 8'hA5;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || fill_level !== 3'd1) begin
            n_fail++;
            $display("FAIL single_push: got valid=%b data=%h fill=%0d, expected 1 a5 1",
                     rx_valid, rx_data, fill_level);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        n_checks++;
        if (rx_valid !== 1'b0 || fill_level !== 3'd0) begin
            n_fail++;
            $display("FAIL single_pop: got valid=%b fill=%0d, expected 0 0", rx_valid, fill_level);
        end
        // Consumer ready with nothing stored must be harmless.
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        n_checks++;
        if (rx_valid !== 1'b0 || fill_level !== 3'd0 || data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got valid=%b fill=%0d ready=%b, expected 0 0 1",
                     rx_valid, fill_level, data_ready);
        end
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= DEPTH; i++) begin
            data_in    = DW'(i);
            data_valid = 1'b1;
            step();
        end
        n_checks++;
        if (fill_level !== 3'd4 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got fill=%0d ready=%b, expected 4 0", fill_level, data_ready);
        end
        data_in = 8'h05;
        repeat (2) step();
        n_checks++;
        if (fill_level !== 3'd4 || rx_data !== 8'h01) begin
            n_fail++;
            $display("FAIL full_hold: got fill=%0d data=%h, expected 4 01", fill_level, rx_data);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        n_checks++;
        if (rx_data !== 8'h02 || data_ready !== 1'b1 || fill_level !== 3'd3) begin
            n_fail++;
            $display("FAIL full_pop: got data=%h ready=%b fill=%0d, expected 02 1 3",
                     rx_data, data_ready, fill_level);
        end
        step();
        data_valid = 1'b0;
        n_checks++;
        if (fill_level !== 3'd4) begin
            n_fail++; $display("FAIL full_refill: got fill=%0d, expected 4", fill_level);
        end
        rx_ready = 1'b1;
        repeat (4) step();
        rx_ready = 1'b0;
        n_checks++;
        if (fill_level !== 3'd0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: got fill=%0d valid=%b, expected 0 0", fill_level, rx_valid);
        end
    endtask

    task automatic test_back_to_back();
        int start_pops;
        start_pops = pop_cnt;
        for (int i = 0; i < 2; i++) begin
            data_in    = 8'h10 + DW'(i);
            data_valid = 1'b1;
            step();
        end
        rx_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            data_in = 8'h10 + DW'(i);
            step();
            n_checks++;
            if (fill_level !== 3'd2) begin
                n_fail++;
                $display("FAIL b2b_fill: cycle %0d got fill=%0d, expected 2", i, fill_level);
            end
        end
        data_valid = 1'b0;
        repeat (2) step();
        rx_ready = 1'b0;
        n_checks++;
        if (pop_cnt - start_pops != 12 || sb_q.size() != 0 || fill_level !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_count: got pops=%0d left=%0d fill=%0d, expected 12 0 0",
                     pop_cnt - start_pops, sb_q.size(), fill_level);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            data_in    = 8'h31 + DW'(i);
            data_valid = 1'b1;
            step();
        end
        data_valid = 1'b0;
        n_checks++;
        if (fill_level !== 3'd3) begin
            n_fail++; $display("FAIL mid_prefill: got fill=%0d, expected 3", fill_level);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (rx_valid !== 1'b0 || fill_level !== 3'd0 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: got valid=%b fill=%0d ready=%b, expected 0 0 0",
                     rx_valid, fill_level, data_ready);
        end
        sb_q.delete();
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (rx_valid !== 1'b0 || fill_level !== 3'd0 || data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_release: got valid=%b fill=%0d ready=%b, expected 0 0 1",
                     rx_valid, fill_level, data_ready);
        end
        data_in    = 8'h44;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        n_checks++;
        if (rx_data !== 8'h44 || fill_level !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_new_word: got data=%h fill=%0d, expected 44 1", rx_data, fill_level);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

`ifdef HS_SLAVE_CNT_EN
    task automatic test_rx_count();
        do_reset();
        n_checks++;
        if (rx_count !== 16'd0) begin
            n_fail++; $display("FAIL cnt_reset: got %0d, expected 0", rx_count);
        end
        data_in    = 8'h77;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        rx_ready   = 1'b1;
        step();
        rx_ready   = 1'b0;
        n_checks++;
        if (rx_count !== 16'd1) begin
            n_fail++; $display("FAIL cnt_pop_only: got %0d, expected 1", rx_count);
        end
        do_reset();
        data_valid = 1'b1;
        rx_ready   = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            data_in = DW'(i);
            step();
        end
        data_valid = 1'b0;
        n_checks++;
        if (rx_count !== 16'd1) begin
            n_fail++; $display("FAIL cnt_wrap: got %0d, expected 1", rx_count);
        end
        repeat (2) step();
        rx_ready = 1'b0;
        n_checks++;
        if (rx_count !== 16'd1 || fill_level !== 3'd0) begin
            n_fail++;
            $display("FAIL cnt_drain: got cnt=%0d fill=%0d, expected 1 0", rx_count, fill_level);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_full();
        test_back_to_back();
        test_reset_mid();
`ifdef HS_SLAVE_CNT_EN
        test_rx_count();
`endif
        step();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d words pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
